// File: rtl/ising_axil_loader_if.sv
// AXI4-Lite slave channel bundle for the Ising sampler loader.
// Address is 6 bits (16 word registers); data width follows the loader.
interface ising_axil_loader_if #(
  parameter int DATA_W = 32
);
  logic [5:0]          s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [5:0]          s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/ising_axil_loader.sv
// AXI4-Lite front-end for the Ising sampler: turns register writes into
// column-sequenced load beats and sequences multi-iteration core runs.
module ising_axil_loader #(
  parameter int N           = 8,
  parameter int DATA_W      = 32,
  parameter int NOISE_BANKS = 2,
  parameter int ITER_W      = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  ising_axil_loader_if.slave   s_axi,
  output logic                 ld_valid,
  output logic [1:0]           ld_bank,
  output logic [9:0]           ld_row,
  output logic [$clog2(N)-1:0] ld_col,
  output logic [DATA_W-1:0]    ld_data,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [N-1:0]         core_spins
);
  localparam int CW  = $clog2(N + 1);
  localparam int LCW = $clog2(N);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic              r_awrdy, r_bvalid, r_ardy, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic [10:0]       r_target;
  logic [ITER_W-1:0] r_iters, r_iter;
  logic [N-1:0]      r_spins;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf, r_err, r_done;
  logic              r_ld_valid;
  logic [1:0]        r_ld_bank;
  logic [9:0]        r_ld_row;
  logic [LCW-1:0]    r_ld_col;
  logic [DATA_W-1:0] r_ld_data;

  logic              w_wr_hs, w_rd_hs, w_busy, w_full;
  logic              w_tgt_w, w_tgt_t, w_tgt_n, w_kind_ok;
  logic [3:0]        w_waddr, w_raddr;
  logic [DATA_W-1:0] w_wdata, w_status, w_rdata;
  logic              w_slverr, w_beat, w_set_err, w_set_ovf, w_rd_ok;
  logic              w_unused;

  assign w_wr_hs = r_awrdy & s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
  assign w_rd_hs = r_ardy & s_axi.s_axi_arvalid;
  assign w_waddr = s_axi.s_axi_awaddr[5:2];
  assign w_raddr = s_axi.s_axi_araddr[5:2];
  assign w_wdata = s_axi.s_axi_wdata;
  assign w_busy  = (r_state != S_IDLE);
  assign w_full  = (r_cnt == CW'(N));
  // Full-word writes only; byte strobes carry no meaning for these registers.
  assign w_unused = ^{s_axi.s_axi_wstrb, s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  // TARGET kinds: weight row < N, threshold at 0x400, noise banks just above.
  assign w_tgt_w   = !r_target[10] && (r_target[9:0] < 10'(N));
  assign w_tgt_t   = (r_target == 11'h400);
  assign w_tgt_n   = r_target[10] && (r_target[9:0] != 10'd0) &&
                     (r_target[9:0] <= 10'(NOISE_BANKS));
  assign w_kind_ok = (w_waddr == 4'h0 && w_tgt_w) || (w_waddr == 4'h1 && w_tgt_n) ||
                     (w_waddr == 4'h2 && w_tgt_t);
  assign w_status  = DATA_W'({16'(r_iter), 8'(r_cnt), 3'b000,
                              r_err, r_ovf, w_full, r_done, w_busy});

  always_comb begin
    w_slverr  = 1'b0;
    w_beat    = 1'b0;
    w_set_err = 1'b0;
    w_set_ovf = 1'b0;
    case (w_waddr)
      4'h0, 4'h1, 4'h2: begin
        if (w_busy) w_slverr = 1'b1;
        else if (!w_kind_ok) begin w_slverr = 1'b1; w_set_err = 1'b1; end
        else if (w_full) begin w_slverr = 1'b1; w_set_ovf = 1'b1; end
        else w_beat = 1'b1;
      end
      4'h3: ;
      4'h5: if (w_wdata[0] && (w_busy || r_iters == '0)) w_slverr = 1'b1;
      4'h6: if (w_busy) w_slverr = 1'b1;
      4'hF: if (w_wdata[0] && w_busy) w_slverr = 1'b1;
      default: begin w_slverr = 1'b1; w_set_err = 1'b1; end
    endcase
  end

  // Write-only registers read back as zero; unmapped reads return SLVERR.
  always_comb begin
    w_rdata = '0;
    w_rd_ok = 1'b1;
    case (w_raddr)
      4'h3: w_rdata = DATA_W'(r_target);
      4'h4: w_rdata = w_status;
      4'h6: w_rdata = DATA_W'(r_iters);
      4'h7: w_rdata = DATA_W'(r_spins);
      4'h0, 4'h1, 4'h2, 4'h5, 4'hF: ;
      default: w_rd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_awrdy <= 1'b0; r_bvalid <= 1'b0; r_bresp <= 2'b00;
      r_ardy <= 1'b0; r_rvalid <= 1'b0; r_rresp <= 2'b00; r_rdata <= '0;
      r_target <= '0; r_iters <= ITER_W'(1); r_iter <= '0; r_spins <= '0;
      r_cnt <= '0; r_ovf <= 1'b0; r_err <= 1'b0; r_done <= 1'b0;
      r_ld_valid <= 1'b0; r_ld_bank <= '0; r_ld_row <= '0; r_ld_col <= '0; r_ld_data <= '0;
    end else begin
      r_awrdy    <= !r_awrdy && s_axi.s_axi_awvalid && s_axi.s_axi_wvalid && !r_bvalid;
      r_ardy     <= !r_ardy && s_axi.s_axi_arvalid && !r_rvalid;
      r_ld_valid <= 1'b0;
      if (r_bvalid && s_axi.s_axi_bready) r_bvalid <= 1'b0;
      if (r_rvalid && s_axi.s_axi_rready) r_rvalid <= 1'b0;

      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
      end

      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_slverr ? 2'b10 : 2'b00;
        if (w_set_err) r_err <= 1'b1;
        if (w_set_ovf) r_ovf <= 1'b1;
        if (w_beat) begin
          r_ld_valid <= 1'b1;
          r_ld_bank  <= (w_waddr == 4'h0) ? 2'd0 : (w_waddr == 4'h1) ? 2'd2 : 2'd1;
          r_ld_row   <= w_tgt_w ? r_target[9:0] : w_tgt_n ? r_target[9:0] - 10'd1 : 10'd0;
          r_ld_col   <= r_cnt[LCW-1:0];
          r_ld_data  <= w_wdata;
          r_cnt      <= r_cnt + 1'b1;
        end
        if (!w_slverr) begin
          case (w_waddr)
            4'h3: begin r_target <= w_wdata[10:0]; r_cnt <= '0; end
            4'h6: r_iters <= w_wdata[ITER_W-1:0];
            4'hF: if (w_wdata[0]) begin
              r_cnt <= '0; r_ovf <= 1'b0; r_err <= 1'b0; r_done <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      case (r_state)
        S_IDLE: if (w_wr_hs && w_waddr == 4'h5 && w_wdata[0] && !w_slverr) begin
          r_state <= S_ISSUE;
          r_iter  <= '0;
          r_done  <= 1'b0;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (core_done) begin
          r_spins <= core_spins;
          r_iter  <= r_iter + 1'b1;
          if ((r_iter + 1'b1) < r_iters) r_state <= S_ISSUE;
          else begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axi.s_axi_awready = r_awrdy;
  assign s_axi.s_axi_wready  = r_awrdy;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_arready = r_ardy;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign ld_valid   = r_ld_valid;
  assign ld_bank    = r_ld_bank;
  assign ld_row     = r_ld_row;
  assign ld_col     = r_ld_col;
  assign ld_data    = r_ld_data;
  assign core_start = (r_state == S_ISSUE);
endmodule

// File: tb/tb_ising_axil_loader.sv
// Scoreboarded bench for ising_axil_loader: a register-level model predicts
// B/R responses and load beats; a monitor pops and compares as they appear.
module tb_ising_axil_loader;
  localparam int N = 8, DATA_W = 32, NB = 2, ITER_W = 16;

  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic                 ld_valid, core_start;
  logic [1:0]           ld_bank;
  logic [9:0]           ld_row;
  logic [$clog2(N)-1:0] ld_col;
  logic [DATA_W-1:0]    ld_data;
  logic                 core_done = 1'b0;
  logic [N-1:0]         core_spins = '0;

  ising_axil_loader_if #(.DATA_W(DATA_W)) axi();

  ising_axil_loader #(.N(N), .DATA_W(DATA_W), .NOISE_BANKS(NB), .ITER_W(ITER_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axi(axi),
    .ld_valid(ld_valid), .ld_bank(ld_bank), .ld_row(ld_row), .ld_col(ld_col),
    .ld_data(ld_data), .core_start(core_start), .core_done(core_done),
    .core_spins(core_spins)
  );

  int n_chk = 0, n_err = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [46:0] exp_ld[$];
  logic [1:0]  e_b;
  logic [33:0] e_r;
  logic [46:0] e_ld;

  int starts = 0, dones = 0, done_cd = -1;
  bit stray_req = 1'b0;
  logic [N-1:0] last_spins = '0;

  // Reference register file
  int m_target, m_iters, m_cnt, m_iter_done;
  bit m_ovf, m_err, m_done, m_busy;
  logic [N-1:0] m_spins;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bump_fail(input string name);
    n_chk++; n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic model_reset();
    m_target = 0; m_iters = 1; m_cnt = 0; m_iter_done = 0;
    m_ovf = 0; m_err = 0; m_done = 0; m_busy = 0; m_spins = '0;
  endtask

  // 0 weight, 1 threshold, 2 noise, -1 illegal (values double as ld_bank)
  function automatic int kind_of(input int t);
    if (t < 1024) return (t < N) ? 0 : -1;
    if (t == 1024) return 1;
    if (t <= 1024 + NB) return 2;
    return -1;
  endfunction

  task automatic mw(input logic [5:0] a, input logic [31:0] d);
    int off, k, want, row;
    logic [1:0] resp;
    off = int'(a[5:2]); resp = 2'b00;
    case (off)
      0, 1, 2: begin
        want = (off == 0) ? 0 : (off == 1) ? 2 : 1;
        k = kind_of(m_target);
        if (m_busy) resp = 2'b10;
        else if (k != want) begin resp = 2'b10; m_err = 1; end
        else if (m_cnt == N) begin resp = 2'b10; m_ovf = 1; end
        else begin
          row = (k == 0) ? m_target : (k == 2) ? m_target - 1025 : 0;
          exp_ld.push_back({2'(k), 10'(row), 3'(m_cnt), d});
          m_cnt++;
        end
      end
      3: begin m_target = int'(d[10:0]); m_cnt = 0; end
      5: if (d[0]) begin
        if (m_busy || m_iters == 0) resp = 2'b10;
        else begin m_busy = 1; m_done = 0; m_iter_done = 0; end
      end
      6: if (m_busy) resp = 2'b10; else m_iters = int'(d[15:0]);
      15: if (d[0]) begin
        if (m_busy) resp = 2'b10;
        else begin m_cnt = 0; m_ovf = 0; m_err = 0; m_done = 0; end
      end
      default: begin resp = 2'b10; m_err = 1; end
    endcase
    exp_b.push_back(resp);
  endtask

  task automatic mr(input logic [5:0] a);
    logic [31:0] d;
    logic [1:0]  resp;
    d = '0; resp = 2'b00;
    case (int'(a[5:2]))
      3: d = 32'(m_target);
      4: d = {16'(m_iter_done), 8'(m_cnt), 3'b000, m_err, m_ovf, (m_cnt == N), m_done, m_busy};
      6: d = 32'(m_iters);
      7: d = 32'(m_spins);
      default: ;
    endcase
    exp_r.push_back({resp, d});
  endtask

  task automatic xfer(input bit dw, input logic [5:0] wa, input logic [31:0] wd,
                      input bit dr, input logic [5:0] ra);
    int t;
    bit hw, hr;
    if (dr) mr(ra);
    if (dw) mw(wa, wd);
    @(posedge aclk); #1;
    if (dw) begin
      axi.s_axi_awaddr = wa; axi.s_axi_wdata = wd; axi.s_axi_wstrb = '1;
      axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    end
    if (dr) begin axi.s_axi_araddr = ra; axi.s_axi_arvalid = 1'b1; end
    t = 0;
    while ((axi.s_axi_awvalid || axi.s_axi_arvalid) && t < 50) begin
      @(negedge aclk);
      hw = axi.s_axi_awready && axi.s_axi_wready;
      hr = axi.s_axi_arready;
      @(posedge aclk); #1;
      if (hw) begin axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; end
      if (hr) axi.s_axi_arvalid = 1'b0;
      t++;
    end
    if (t >= 50) begin
      bump_fail("addr_handshake_timeout");
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
    end
    t = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && t < 100) begin
      @(negedge aclk); t++;
    end
    if (t >= 100) begin
      bump_fail("response_timeout");
      exp_b.delete(); exp_r.delete();
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d); xfer(1, a, d, 0, 6'h0); endtask
  task automatic rd(input logic [5:0] a); xfer(0, 6'h0, 32'h0, 1, a); endtask

  task automatic ld_drained(input string name);
    repeat (2) @(negedge aclk);
    chk(name, 64'(exp_ld.size()), 64'd0);
    exp_ld.delete();
  endtask

  task automatic finish_run(input int s0, input int d0);
    int t;
    t = 0;
    while (!(starts - s0 >= m_iters && dones - d0 >= m_iters) && t < 3000) begin
      @(posedge aclk); t++;
    end
    if (t >= 3000) bump_fail("run_timeout");
    repeat (30) @(posedge aclk);
    chk("start_count", 64'(starts - s0), 64'(m_iters));
    m_busy = 0; m_done = 1; m_iter_done = m_iters; m_spins = last_spins;
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0; done_cd = -1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  // Backpressure on the response channels
  initial begin
    axi.s_axi_bready = 1'b0; axi.s_axi_rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      axi.s_axi_bready = ($urandom_range(0, 3) != 0);
      axi.s_axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  // Core model: finishes each iteration 10 cycles after its start pulse
  initial forever begin
    @(posedge aclk); #1;
    core_done = 1'b0;
    if (stray_req) begin
      core_done = 1'b1; core_spins = 8'hA5; stray_req = 1'b0;
    end else if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        core_done = 1'b1; core_spins = N'($urandom_range(0, 255));
        last_spins = core_spins; dones++; done_cd = -1;
      end
    end
    if (core_start && aresetn) done_cd = 10;
  end

  // Monitor
  initial forever begin
    @(negedge aclk);
    if (aresetn) begin
      if (core_start) starts++;
      if (axi.s_axi_bvalid && axi.s_axi_bready) begin
        if (exp_b.size() == 0) bump_fail("b_unexpected");
        else begin e_b = exp_b.pop_front(); chk("bresp", 64'(axi.s_axi_bresp), 64'(e_b)); end
      end
      if (axi.s_axi_rvalid && axi.s_axi_rready) begin
        if (exp_r.size() == 0) bump_fail("r_unexpected");
        else begin
          e_r = exp_r.pop_front();
          chk("rdata_rresp", 64'({axi.s_axi_rresp, axi.s_axi_rdata}), 64'(e_r));
        end
      end
      if (ld_valid) begin
        if (exp_ld.size() == 0) bump_fail("ld_unexpected");
        else begin
          e_ld = exp_ld.pop_front();
          chk("ld_beat", 64'({ld_bank, ld_row, ld_col, ld_data}), 64'(e_ld));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int tg[9] = '{0, 3, 7, 8, 1023, 1024, 1025, 1026, 1027};
  int s0, d0;

  initial begin
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0; axi.s_axi_wdata = '0;
    axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0; axi.s_axi_araddr = '0;
    axi.s_axi_arvalid = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_handshake", 64'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid,
        axi.s_axi_arready, axi.s_axi_rvalid, axi.s_axi_bresp, axi.s_axi_rresp,
        axi.s_axi_rdata, core_start}), 64'd0);
    chk("rst_ld", 64'({ld_valid, ld_bank, ld_row, ld_col, ld_data}), 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    rd(6'h10); rd(6'h0C); rd(6'h18); rd(6'h1C);

    // Weight row 0, then overflow and clear
    wr(6'h0C, 32'h0);
    for (int i = 0; i < N; i++) wr(6'h00, 32'(i % 2 == 0));
    rd(6'h10);
    wr(6'h00, 32'h1);
    rd(6'h10);
    wr(6'h3C, 32'h1);
    rd(6'h10);
    ld_drained("ld_drain_weight");

    // Noise bank 1, then mismatched kind
    wr(6'h0C, 32'h402);
    wr(6'h04, 32'h1); wr(6'h04, 32'h2); wr(6'h04, 32'h3); wr(6'h04, 32'hFFFF_FFFF);
    for (int i = 4; i < N; i++) wr(6'h04, $urandom);
    wr(6'h08, 32'h55);
    rd(6'h10); rd(6'h0C);
    wr(6'h3C, 32'h1);
    ld_drained("ld_drain_noise");

    // Randomized register traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: wr(6'($urandom_range(0, 2) * 4), $urandom);
        3, 4:    wr(6'h0C, 32'(tg[$urandom_range(0, 8)]));
        5:       wr(6'h3C, 32'($urandom_range(0, 1)));
        6:       wr(($urandom_range(0, 1) != 0) ? 6'h10 : 6'h1C, $urandom);
        7, 8:    rd(6'h10);
        default: rd(6'h0C);
      endcase
    end
    ld_drained("ld_drain_random");

    // Same-cycle read and write: STATUS returns the pre-write value
    wr(6'h3C, 32'h1); wr(6'h0C, 32'h3);
    wr(6'h00, 32'hAA); wr(6'h00, 32'hBB);
    xfer(1, 6'h0C, 32'h5, 1, 6'h10);
    rd(6'h10);
    ld_drained("ld_drain_same_cycle");

    // Three-iteration run
    wr(6'h18, 32'd3);
    s0 = starts; d0 = dones;
    wr(6'h14, 32'h1);
    finish_run(s0, d0);
    rd(6'h10); rd(6'h1C); rd(6'h18);

    // Long run with rejected traffic while busy
    wr(6'h18, 32'd20);
    s0 = starts; d0 = dones;
    wr(6'h14, 32'h1);
    wr(6'h14, 32'h1);
    wr(6'h18, 32'd7);
    wr(6'h00, 32'h77);
    wr(6'h3C, 32'h1);
    finish_run(s0, d0);
    rd(6'h18); rd(6'h10); rd(6'h1C);
    ld_drained("ld_drain_busy");

    // Stray core_done while idle is ignored
    stray_req = 1'b1;
    repeat (5) @(posedge aclk);
    rd(6'h1C); rd(6'h10);

    // ITERS=0 refuses to start
    wr(6'h18, 32'd0);
    s0 = starts;
    wr(6'h14, 32'h1);
    repeat (20) @(posedge aclk);
    chk("no_start_iters0", 64'(starts - s0), 64'd0);
    rd(6'h10);

    // Reset in the middle of a run
    wr(6'h0C, 32'h401);
    wr(6'h18, 32'd5);
    wr(6'h14, 32'h1);
    repeat (25) @(posedge aclk);
    pulse_reset();
    @(negedge aclk);
    chk("rst_midrun_core_start", 64'(core_start), 64'd0);
    s0 = starts;
    repeat (40) @(posedge aclk);
    chk("rst_midrun_no_start", 64'(starts - s0), 64'd0);
    rd(6'h10); rd(6'h0C); rd(6'h18); rd(6'h1C);
    ld_drained("ld_drain_final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ising_axil_loader.md
# ising_axil_loader

AXI4-Lite slave front-end for the recurrent Ising sampler core, generalised to N spins, multiple noise banks and multi-iteration runs. Converts host register writes into column-sequenced load beats for the weight, threshold and noise memories. Sequences start/iteration/done handshakes with the core and exposes status and final spin state for readback. Sits between the AXI VIP/PS interconnect and the sampler core.

## Interface
- N, 8: spin count; weight matrix is N×N, one row = N beats
- DATA_W, 32: AXI data width and load-beat width
- NOISE_BANKS, 2: number of noise banks, 1..1023
- ITER_W, 16: iteration counter width
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- s_axi_awaddr/awvalid/awready, s_axi_wdata/wstrb/wvalid/wready, s_axi_bresp/bvalid/bready  AXI4-Lite write channels, 6-bit addr, DATA_W data
- s_axi_araddr/arvalid/arready, s_axi_rdata/rresp/rvalid/rready  AXI4-Lite read channels
- ld_valid  out  1  one-cycle load beat strobe
- ld_bank  out  2  0 weight, 1 threshold, 2 noise
- ld_row  out  10  weight row index or noise bank index (0-based)
- ld_col  out  clog2(N)  column within row
- ld_data  out  DATA_W  beat payload
- core_start  out  1  one-cycle pulse per iteration
- core_done  in  1  one-cycle pulse, iteration finished
- core_spins  in  N  spin vector, valid when core_done

## Operation
- Register map (word offsets): 0x00 WEIGHT_DATA W; 0x04 NOISE_DATA W; 0x08 THRESH_DATA W; 0x0C TARGET RW; 0x10 STATUS R; 0x14 CONTROL W; 0x18 ITERS RW; 0x1C SPINS R; 0x3C CLEAR W.
- TARGET decode: bit10=0 -> weight row TARGET[9:0] (legal < N); TARGET=0x400 -> threshold; 0x401..0x400+NOISE_BANKS -> noise bank (TARGET-0x401). Writing TARGET zeroes beat counter.
- Data write to 0x00/0x04/0x08: accepted only if data register matches TARGET kind and TARGET legal; emits ld_valid with ld_col = beat counter, then counter++. Counter reaching N sets row_full; further data writes dropped, SLVERR, sticky ovf.
- Mismatched kind, illegal TARGET, or unmapped offset: SLVERR, no beat, sticky err.
- CLEAR with wdata[0]=1: zero beat counter, row_full, ovf, err, done; TARGET and ITERS kept. Ignored (SLVERR) while busy.
- CONTROL wdata[0]=1: start run if idle and ITERS≠0; else SLVERR.
- STATUS: [0] busy, [1] done, [2] row_full, [3] ovf, [4] err, [15:8] beat counter, [31:16] iterations completed.
- Run FSM: IDLE -> ISSUE (core_start pulse) -> WAIT (await core_done; capture core_spins to SPINS; iter++) -> ISSUE if iter<ITERS else DONE -> IDLE with done=1. Data writes during run: SLVERR, dropped.
- ITERS write while busy: SLVERR, unchanged.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, ld_* 0, core_start 0, TARGET 0, ITERS 1, SPINS 0, counters/flags 0, FSM IDLE.
- Write: awready and wready asserted together for one cycle only when awvalid&wvalid and no B pending; bvalid next cycle, held until bready. One outstanding write.
- ld_valid asserted the cycle after handshake, exactly one cycle.
- Read: arready one cycle when arvalid and no R pending; rvalid next cycle with data, held until rready.
- core_start asserted 1 cycle after CONTROL handshake; WAIT->ISSUE gap 1 cycle. core_done in IDLE/ISSUE ignored.
- core_done on final iteration: busy falls, done rises same cycle as SPINS update; readable the next read.
- Reset asserted mid-run or mid-transaction: all state to reset values next edge; pending B/R dropped.
- Read and write same cycle: both serviced independently; read of STATUS returns pre-write value.

## Test plan
- Reset, write TARGET=0, then 8 WEIGHT_DATA alternating 1/0 (N=8) -> beats ld_bank=0 ld_row=0 ld_col 0..7, OKAY; STATUS row_full=1, counter=8.
- 9th WEIGHT_DATA -> SLVERR, no ld_valid, STATUS ovf=1; CLEAR=1 -> STATUS 0.
- TARGET=0x402, 8 NOISE_DATA 1,2,3,0xffffffff,... -> ld_bank=2 ld_row=1, data matched; THRESH_DATA there -> SLVERR, err=1.
- ITERS=3, CONTROL=1, model core_done 10 cycles after each start -> 3 core_start pulses, STATUS[31:16]=3, done=1, SPINS = last core_spins.
- CONTROL=1 with ITERS=0, or second start while busy -> SLVERR, no extra core_start.
- aresetn low mid-run for 1 cycle -> busy=0, TARGET=0, ITERS=1, no further core_start.
